// File: rtl/instr_stream_ctrl.sv
// instr_stream_ctrl
//   Sequences the instruction stream into the core and its reference model
//   during lockstep equivalence runs: NOP warm-up, a bounded number of
//   generator instructions with stall back-pressure, a NOP drain, and a
//   check handshake with the comparator.
//
// Optional feature macro: INSTR_FILTER_EN
//   When defined, accepted instructions whose opcode is neither OP-IMM
//   (7'b0010011) nor LOAD (7'b0000011) are consumed but replaced by NOP.
//   These are counted on the extra output filtered_count.
//
// Ports
//   clk            in   single clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   start          in   begin a run (sampled only in IDLE)
//   stall          in   core fetch stall; instr/instr_valid hold while high
//   gen_valid      in   generator has an instruction
//   gen_instr      in   [31:0] generator instruction word
//   gen_ready      out  instruction accepted this cycle (ISSUE && !stall)
//   instr          out  [31:0] registered instruction to core/model fetch
//   instr_valid    out  instr holds a generator instruction, not a NOP
//   issued_count   out  [15:0] instructions accepted in this run
//   busy           out  FSM not in IDLE
//   check_req      out  pipeline drained, comparator may sample
//   check_ack      in   comparator done
//   done           out  one-cycle pulse at end of run
//   filtered_count out  [15:0] filtered instructions (INSTR_FILTER_EN only)
//
// State     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start
// S_WARMUP  | issuing NOPs, warm-up counter decrementing on free cycles
// S_ISSUE   | accepting generator instructions until NUM_INSTRS counted
// S_DRAIN   | issuing NOPs, drain counter incrementing on free cycles
// S_CHECK   | check_req high, waiting for check_ack

module instr_stream_ctrl #(
  parameter int WARMUP_CYCLES = 4,
  parameter int NUM_INSTRS    = 64,
  parameter int DRAIN_CYCLES  = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stall,
  input  logic        gen_valid,
  input  logic [31:0] gen_instr,
  output logic        gen_ready,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [15:0] issued_count,
  output logic        busy,
  output logic        check_req,
  input  logic        check_ack,
  output logic        done
`ifdef INSTR_FILTER_EN
  ,
  output logic [15:0] filtered_count
`endif
);

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [15:0] WARM_LOAD  = 16'(WARMUP_CYCLES);
  localparam logic [15:0] LAST_CNT   = 16'(NUM_INSTRS - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_ISSUE,
    S_DRAIN,
    S_CHECK
  } state_t;

  state_t      state;
  logic [15:0] warm_cnt;
  logic [15:0] drain_cnt;
  logic        accept;
  logic        pass;

  // Combinational so the generator sees back-pressure in the same cycle
  // the core stalls; this also makes stall+accept impossible.
  assign gen_ready = (state == S_ISSUE) && !stall;
  assign accept    = gen_ready && gen_valid;
  assign busy      = (state != S_IDLE);

`ifdef INSTR_FILTER_EN
  assign pass = (gen_instr[6:0] == 7'b0010011) || (gen_instr[6:0] == 7'b0000011);
`else
  assign pass = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      instr        <= NOP;
      instr_valid  <= 1'b0;
      issued_count <= 16'd0;
      check_req    <= 1'b0;
      done         <= 1'b0;
      warm_cnt     <= 16'd0;
      drain_cnt    <= 16'd0;
`ifdef INSTR_FILTER_EN
      filtered_count <= 16'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            issued_count <= 16'd0;
            warm_cnt     <= WARM_LOAD;
`ifdef INSTR_FILTER_EN
            filtered_count <= 16'd0;
`endif
            if (WARMUP_CYCLES == 0) state <= S_ISSUE;
            else                    state <= S_WARMUP;
          end
        end

        S_WARMUP: begin
          if (!stall) begin
            instr       <= NOP;
            instr_valid <= 1'b0;
            warm_cnt    <= warm_cnt - 16'd1;
            if (warm_cnt == 16'd1) state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (accept && pass) begin
            instr        <= gen_instr;
            instr_valid  <= 1'b1;
            issued_count <= issued_count + 16'd1;
            // This accept reaches NUM_INSTRS, so the count can never overshoot.
            if (issued_count == LAST_CNT) begin
              drain_cnt <= 16'd0;
              if (DRAIN_CYCLES == 0) begin
                state     <= S_CHECK;
                check_req <= 1'b1;
              end else begin
                state <= S_DRAIN;
              end
            end
          end else if (!stall) begin
            // Bubble, or a filtered instruction that is consumed as a NOP.
            instr       <= NOP;
            instr_valid <= 1'b0;
`ifdef INSTR_FILTER_EN
            if (accept && (filtered_count != 16'hFFFF))
              filtered_count <= filtered_count + 16'd1;
`endif
          end
        end

        S_DRAIN: begin
          if (!stall) begin
            instr       <= NOP;
            instr_valid <= 1'b0;
            drain_cnt   <= drain_cnt + 16'd1;
            if (drain_cnt == DRAIN_LAST) begin
              state     <= S_CHECK;
              check_req <= 1'b1;
            end
          end
        end

        S_CHECK: begin
          if (check_ack) begin
            state     <= S_IDLE;
            check_req <= 1'b0;
            done      <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          check_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_ctrl.sv
module tb_instr_stream_ctrl;

  localparam int W = 2;
  localparam int N = 20;
  localparam int D = 5;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef INSTR_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        gen_valid = 1'b0;
  logic [31:0] gen_instr = 32'd0;
  logic        check_ack = 1'b0;
  logic        gen_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] issued_count;
  logic        busy;
  logic        check_req;
  logic        done;
`ifdef INSTR_FILTER_EN
  logic [15:0] filtered_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  instr_stream_ctrl #(
    .WARMUP_CYCLES(W),
    .NUM_INSTRS   (N),
    .DRAIN_CYCLES (D)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stall       (stall),
    .gen_valid   (gen_valid),
    .gen_instr   (gen_instr),
    .gen_ready   (gen_ready),
    .instr       (instr),
    .instr_valid (instr_valid),
    .issued_count(issued_count),
    .busy        (busy),
    .check_req   (check_req),
    .check_ack   (check_ack),
    .done        (done)
`ifdef INSTR_FILTER_EN
    ,
    .filtered_count(filtered_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input int i);
    return {12'(i), 5'd1, 3'b000, 5'd1, 7'b0010011};
  endfunction

  // ---------------- reference model (run-level view) ----------------
  typedef enum int {P_IDLE, P_WARM, P_ISSUE, P_DRAIN, P_CHECK} phase_t;
  phase_t      m_phase = P_IDLE;
  int          m_left  = 0;
  logic [31:0] m_instr = NOP;
  bit          m_valid = 1'b0;
  int          m_cnt   = 0;
  int          m_filt  = 0;
  bit          m_req   = 1'b0;
  bit          m_done  = 1'b0;

  function automatic bit keeps(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    return !FILT || op == 7'b0010011 || op == 7'b0000011;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = P_IDLE; m_left = 0; m_instr = NOP; m_valid = 1'b0;
      m_cnt = 0; m_filt = 0; m_req = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        P_IDLE: if (start) begin
          m_cnt = 0; m_filt = 0;
          if (W == 0) m_phase = P_ISSUE;
          else begin m_phase = P_WARM; m_left = W; end
        end
        P_WARM: if (!stall) begin
          m_instr = NOP; m_valid = 1'b0; m_left--;
          if (m_left == 0) m_phase = P_ISSUE;
        end
        P_ISSUE: if (!stall) begin
          if (gen_valid && keeps(gen_instr)) begin
            m_instr = gen_instr; m_valid = 1'b1; m_cnt++;
            if (m_cnt == N) begin
              if (D == 0) begin m_phase = P_CHECK; m_req = 1'b1; end
              else begin m_phase = P_DRAIN; m_left = D; end
            end
          end else begin
            m_instr = NOP; m_valid = 1'b0;
            if (gen_valid) m_filt++;
          end
        end
        P_DRAIN: if (!stall) begin
          m_instr = NOP; m_valid = 1'b0; m_left--;
          if (m_left == 0) begin m_phase = P_CHECK; m_req = 1'b1; end
        end
        P_CHECK: if (check_ack) begin
          m_phase = P_IDLE; m_req = 1'b0; m_done = 1'b1;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_instr", instr, m_instr);
      chk("cyc_instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("cyc_gen_ready", 32'(gen_ready), 32'(m_phase == P_ISSUE && !stall));
      chk("cyc_issued_count", 32'(issued_count), 32'(m_cnt));
      chk("cyc_busy", 32'(busy), 32'(m_phase != P_IDLE));
      chk("cyc_check_req", 32'(check_req), 32'(m_req));
      chk("cyc_done", 32'(done), 32'(m_done));
`ifdef INSTR_FILTER_EN
      chk("cyc_filtered_count", 32'(filtered_count), 32'(m_filt));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] w [0:2];
  int k;

  initial begin
    w[0] = 32'h00A08093; w[1] = 32'h00412103; w[2] = 32'h7FF18193;

    #2 reset_n = 1'b0;
    #19;
    chk("rst_instr", instr, NOP);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_gen_ready", 32'(gen_ready), 32'd0);
    chk("rst_issued_count", 32'(issued_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_check_req", 32'(check_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    tick();

    // Basic run with bubbles and a stall inside ISSUE
    start = 1'b1; gen_valid = 1'b1; gen_instr = w[0];
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("warm_gen_ready", 32'(gen_ready), 32'd0);
    tick(); tick();
    chk("warm_nop", instr, NOP);
    chk("issue_gen_ready", 32'(gen_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      gen_instr = w[i];
      tick();
      chk("basic_instr", instr, w[i]);
      chk("basic_valid", 32'(instr_valid), 32'd1);
    end
    chk("basic_count", 32'(issued_count), 32'd3);

    gen_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bubble_instr", instr, NOP);
      chk("bubble_valid", 32'(instr_valid), 32'd0);
      chk("bubble_count", 32'(issued_count), 32'd3);
    end

    gen_valid = 1'b1; gen_instr = word(3);
    tick();
    chk("pre_stall_instr", instr, word(3));
    stall = 1'b1; gen_instr = word(99);
    #1;
    chk("stall_gen_ready", 32'(gen_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", instr, word(3));
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_count", 32'(issued_count), 32'd4);
    end
    stall = 1'b0;

    // start and check_ack mid-run must be ignored
    start = 1'b1; check_ack = 1'b1;
    for (int i = 4; i < N; i++) begin
      gen_instr = word(i);
      tick();
      start = 1'b0; check_ack = 1'b0;
    end
    chk("last_instr", instr, word(N - 1));
    chk("full_count", 32'(issued_count), 32'(N));

    // Drain with 4 stalled cycles: check_req 4 edges later than D
    stall = 1'b1;
    repeat (4) tick();
    stall = 1'b0;
    chk("drain_stall_req", 32'(check_req), 32'd0);
    k = 0;
    while (!check_req && k < 40) begin
      tick();
      k++;
    end
    chk("drain_edges_after_stall", 32'(k), 32'd5);

    // Handshake end
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      tick();
      chk("hold_check_req", 32'(check_req), 32'd1);
    end
    start = 1'b0;
    check_ack = 1'b1;
    tick();
    check_ack = 1'b0;
    chk("ack_check_req", 32'(check_req), 32'd0);
    chk("ack_done", 32'(done), 32'd1);
    chk("ack_busy", 32'(busy), 32'd0);
    chk("ack_count_hold", 32'(issued_count), 32'(N));
    tick();
    chk("done_pulse_end", 32'(done), 32'd0);

    // Second run: filter words first, then mid-run reset at issued_count=17
    start = 1'b1; gen_valid = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    gen_instr = 32'h00000033;
    tick();
    chk("rtype_instr", instr, FILT ? NOP : 32'h00000033);
    chk("rtype_valid", 32'(instr_valid), FILT ? 32'd0 : 32'd1);
`ifdef INSTR_FILTER_EN
    chk("rtype_filtered", 32'(filtered_count), 32'd1);
`endif
    gen_instr = 32'h00008083;
    tick();
    chk("load_instr", instr, 32'h00008083);
    chk("load_valid", 32'(instr_valid), 32'd1);
    chk("load_count", 32'(issued_count), FILT ? 32'd1 : 32'd2);
    for (int i = 0; i < (FILT ? 16 : 15); i++) begin
      gen_instr = word(200 + i);
      tick();
    end
    chk("pre_reset_count", 32'(issued_count), 32'd17);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_instr", instr, NOP);
    chk("midrst_count", 32'(issued_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_gen_ready", 32'(gen_ready), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // Fresh run after reset with an irregular valid pattern
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 300; j++) begin
      gen_valid = (j % 3) != 2;
      gen_instr = word(300 + j);
      tick();
      if (check_req) break;
    end
    gen_valid = 1'b0;
    chk("rerun_check_req", 32'(check_req), 32'd1);
    chk("rerun_count", 32'(issued_count), 32'(N));
    check_ack = 1'b1;
    tick();
    check_ack = 1'b0;
    chk("rerun_done", 32'(done), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
